// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath constants and types
package calc_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
    function automatic bit digits_cover_width(input int digits, input int width);
        longint p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p > ((longint'(1) << width) - 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit corrector (add 3 when digit >= 5)
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/prod_to_bcd.sv
// rtl/prod_to_bcd.sv - sequential binary-to-BCD converter for the multiplier product
module prod_to_bcd
    import calc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        mag,
    input  logic                    negative,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    sign,
    output logic [2:0]              ndig
);

    localparam int BW = BCD_W * DIGITS;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     work_q, work_d;
    logic              neg_q, neg_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              sign_q, sign_d;
    logic [2:0]        ndig_q, ndig_d;

    logic [BW-1:0]     corr;
    logic [BW-1:0]     shifted;
    logic [2:0]        ndig_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[g*BCD_W +: BCD_W]),
            .digit_o (corr[g*BCD_W +: BCD_W])
        );
    end

    // The working BCD register is kept apart from the output register so the
    // last result stays visible while the next operand is being converted.
    assign shifted = {corr[BW-2:0], bin_q[WIDTH-1]};

    always_comb begin
        ndig_next = 3'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[i*BCD_W +: BCD_W] != '0) begin
                ndig_next = 3'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        work_d  = work_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        ndig_d  = ndig_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = mag;
                    work_d  = '0;
                    neg_d   = negative & (mag != '0);
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bin_d  = {bin_q[WIDTH-2:0], 1'b0};
                work_d = shifted;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    bcd_d   = shifted;
                    sign_d  = neg_q;
                    ndig_d  = ndig_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            work_q  <= '0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            ndig_q  <= 3'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            ndig_q  <= ndig_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign sign      = sign_q;
    assign ndig      = ndig_q;

endmodule

// File: tb/tb_prod_to_bcd.sv
// tb/tb_prod_to_bcd.sv - self-checking bench for prod_to_bcd
module tb_prod_to_bcd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mag;
    logic        negative;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd;
    logic        sign;
    logic [2:0]  ndig;

    int vectors = 0;
    int errors  = 0;

    prod_to_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag       (mag),
        .negative  (negative),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .sign      (sign),
        .ndig      (ndig)
    );

    always #5 clk = ~clk;

    // Decimal reference model
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [2:0] ref_ndig(input int unsigned v);
        int unsigned t;
        int n;
        t = v;
        n = 1;
        while (t >= 10) begin
            t = t / 10;
            n++;
        end
        return 3'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] m, input logic n, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        mag      = m;
        negative = n;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 20'h0 || sign !== 1'b0 || ndig !== 3'd1) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b bcd=%h sign=%b ndig=%0d, want 1 0 00000 0 1",
                     in_ready, out_valid, bcd, sign, ndig);
        end
    endtask

    task automatic test_single(input string name, input logic [15:0] m, input logic n);
        int lat;
        send(m, n, lat);
        vectors++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want 16", name, lat);
        end
        vectors++;
        if (bcd !== ref_bcd(m) || sign !== (n && m != 0) || ndig !== ref_ndig(m)) begin
            errors++;
            $display("FAIL %s result: bcd=%h sign=%b ndig=%0d, want bcd=%h sign=%b ndig=%0d",
                     name, bcd, sign, ndig, ref_bcd(m), n && m != 0, ref_ndig(m));
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [15:0] m;
        m = 16'd12345;
        send(m, 1'b1, lat);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid = c[0];
            mag      = 16'(c * 977);
            negative = 1'b0;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd !== ref_bcd(m) || sign !== 1'b1 || ndig !== ref_ndig(m)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL backpressure hold c=%0d: out_valid=%b in_ready=%b bcd=%h sign=%b ndig=%0d, want 1 0 %h 1 %0d",
                             c, out_valid, in_ready, bcd, sign, ndig, ref_bcd(m), ref_ndig(m));
            end
        end
        in_valid = 1'b0;
        consume();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd !== ref_bcd(m)) begin
            errors++;
            $display("FAIL backpressure release: out_valid=%b in_ready=%b bcd=%h, want 0 1 %h",
                     out_valid, in_ready, bcd, ref_bcd(m));
        end
    endtask

    task automatic test_reset_mid();
        mag      = 16'd54321;
        negative = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 20'h0 || sign !== 1'b0 || ndig !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b bcd=%h sign=%b ndig=%0d, want 1 0 00000 0 1",
                     in_ready, out_valid, bcd, sign, ndig);
        end
        test_single("after_reset_9", 16'd9, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_mag[$];
        logic        exp_neg[$];
        int          issued, received, cyc, last_acc, acc_cyc[$];
        logic [15:0] m;
        logic        n;
        int          r;
        issued   = 0;
        received = 0;
        cyc      = 0;
        last_acc = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (received < 200 && cyc < 5000) begin
            if (out_valid) begin
                m = exp_mag.pop_front();
                n = exp_neg.pop_front();
                r = acc_cyc.pop_front();
                vectors++;
                if (bcd !== ref_bcd(m) || sign !== (n && m != 0) || ndig !== ref_ndig(m) || cyc - r !== 17) begin
                    errors++;
                    $display("FAIL b2b #%0d mag=%0d: bcd=%h sign=%b ndig=%0d lat=%0d, want bcd=%h sign=%b ndig=%0d lat=17",
                             received, m, bcd, sign, ndig, cyc - r, ref_bcd(m), n && m != 0, ref_ndig(m));
                end
                received++;
            end
            if (in_ready) begin
                if (issued < 200) begin
                    r = $urandom_range(0, 9);
                    if (r == 0)      m = 16'h0000;
                    else if (r == 1) m = 16'hFFFF;
                    else if (r == 2) m = 16'($urandom_range(0, 99));
                    else             m = 16'($urandom);
                    n = 1'($urandom);
                    mag      = m;
                    negative = n;
                    exp_mag.push_back(m);
                    exp_neg.push_back(n);
                    acc_cyc.push_back(cyc);
                    if (last_acc >= 0) begin
                        vectors++;
                        if (cyc - last_acc !== 18) begin
                            errors++;
                            $display("FAIL b2b spacing #%0d: got %0d cycles, want 18", issued, cyc - last_acc);
                        end
                    end
                    last_acc = cyc;
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (received !== 200) begin
            errors++;
            $display("FAIL b2b count: got %0d results, want 200", received);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mag       = '0;
        negative  = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_single("zero_sign", 16'h0000, 1'b1);
        test_single("full_scale", 16'hFFFF, 1'b0);
        test_single("max_product", 16'd65025, 1'b1);
        test_single("hundred", 16'd100, 1'b0);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/prod_to_bcd.md
Name: prod_to_bcd

Overview:
- Downstream stage of the 8x8 Wallace multiplier in the calculator datapath.
- Accepts the 16-bit unsigned product magnitude and its sign flag, and converts the magnitude to 5 packed BCD digits using sequential double-dabble (shift-and-add-3), one bit per clock.
- Delivers the digits, sign and significant-digit count to the display driver over a valid/ready handshake.

Parameters:
- WIDTH, 16, magnitude width in bits.
- DIGITS, 5, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1. Only the defaults are verified.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- in_valid  input  1  mag/negative are valid.
- in_ready  output  1  block can accept a new operand.
- mag  input  WIDTH  unsigned product magnitude (multiplier p).
- negative  input  1  product sign (multiplier negative).
- out_valid  output  1  bcd/sign/ndig are valid.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*DIGITS  packed BCD; [3:0] is the units digit, [4*DIGITS-1:4*DIGITS-4] is the most significant.
- sign  output  1  result is negative; forced 0 when mag==0.
- ndig  output  3  count of significant digits, 1..DIGITS; 0 yields 1.

Behaviour:
- States: IDLE, CONV, DONE.
- Reset values, applied on a clk edge with rst_n=0 from any state, including mid-CONV: state=IDLE, in_ready=1, out_valid=0, bcd=0, sign=0, ndig=1, shift register=0, counter=0. A conversion in progress is discarded.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, latch mag into the binary shift register, clear the BCD register, capture sign = negative & (mag!=0), counter=0, go to CONV.
- CONV:
  - in_ready=0, out_valid=0; in_valid is ignored.
  - Each edge: every BCD digit >=5 gets +3 (combinational, before the shift); then {bcd_reg, bin_reg} shifts left 1; counter increments.
  - On the edge where counter==WIDTH-1, the final shift completes, ndig is registered from the final digits, and the state goes to DONE.
  - Exactly WIDTH (16) edges are spent in CONV.
- DONE:
  - out_valid=1; bcd, sign and ndig are held stable while out_valid=1 and out_ready=0 (indefinite backpressure).
  - On an edge with out_ready=1, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - in_ready stays 0 in DONE; no bypass path.
- Latency: operand accepted at edge E0, so out_valid is first high after edge E16.
- Minimum spacing between accepted operands: 18 cycles with out_ready tied high.
- Output registers bcd/sign/ndig keep the last result after leaving DONE until the next conversion completes; consumers sample them only under out_valid.
- ndig = 1 + index of the highest nonzero digit, or 1 if all digits are zero.
- Arithmetic:
  - Digit correction is 4-bit; a corrected digit never exceeds 4'hC before the shift, so no digit overflow can occur.
  - Inputs beyond 10^DIGITS-1 cannot occur given the parameter rule.
- Simultaneous events: rst_n=0 dominates all handshakes. in_valid during CONV/DONE is neither accepted nor queued; the upstream stage holds it.

Decomposition:
- Shared package calc_pkg holds:
  - BCD digit width constant (4)
  - ADD3_THRESH constant (5)
  - state encoding constants (IDLE=2'd0, CONV=2'd1, DONE=2'd2)
  - the DIGITS/WIDTH legality relation, for reuse by the display driver.
- One sub-module: bcd_add3, a combinational 4-bit digit corrector (out = in>=5 ? in+3 : in), instantiated DIGITS times in a generate loop.
- The FSM, counter, shift registers and ndig logic stay in prod_to_bcd.

Test Plan:
- Zero with sign: mag=0, negative=1 -> after 16 cycles out_valid=1, bcd=20'h00000, sign=0, ndig=1.
- Full scale: mag=16'hFFFF, negative=0 -> bcd=20'h65535, sign=0, ndig=5; out_valid rises exactly 16 edges after acceptance.
- Max 8x8 product: mag=16'd65025 (255*255), negative=1 -> bcd=20'h65025, sign=1, ndig=5. Also mag=16'd100 -> bcd=20'h00100, ndig=3.
- Backpressure: out_ready=0 for 40 cycles after out_valid; bcd/sign/ndig stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 for 1 cycle -> IDLE and in_ready=1 next cycle.
- Reset mid-operation: assert rst_n=0 for one edge at counter=7 -> IDLE, all outputs at reset values. Next operand mag=16'd9 -> bcd=20'h00009, ndig=1, with correct latency.
- Back-to-back stream: in_valid and out_ready held high, 200 random mags compared against a decimal model; acceptance spacing is exactly 18 cycles.
